filter_sequencer: RTL and testbench



---
 rtl/filter_pkg.sv | 29 ++
 rtl/filter_sequencer_if.sv | 24 ++
 rtl/filter_port_mux.sv | 28 ++
 rtl/filter_sequencer.sv | 128 ++++++++++++
 tb/tb_filter_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_pkg.sv
// Shared definitions for the filter sequencer: state codes, DMOD bit map,
// default RAM address width.
package filter_pkg;

   // Default filtered-image RAM address width
   localparam int FILTER_ADDR_W = 13;

   // Sequencer state codes (3-bit, registered)
   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_WAIT_BLANK = 3'd1;
   localparam logic [2:0] ST_START      = 3'd2;
   localparam logic [2:0] ST_RUN        = 3'd3;
   localparam logic [2:0] ST_DONE       = 3'd4;
   localparam logic [2:0] ST_ERR        = 3'd5;

   // DMOD SFR bit positions
   localparam int DMOD_EN      = 0;
   localparam int DMOD_SEL_LSB = 1;
   localparam int DMOD_SEL_MSB = 3;
   localparam int DMOD_MODE    = 4;
   localparam int DMOD_RES     = 5;
   localparam int DMOD_NEWTXT  = 6;

   // The accelerator owns RAM port 0 only while it is being started or running
   function automatic logic acc_owns_port(input logic [2:0] state);
      return (state == ST_START) || (state == ST_RUN);
   endfunction

endpackage

// File: rtl/filter_sequencer_if.sv
// Accelerator-side bundle: start/done handshake, configuration snapshot and
// the accelerator's RAM port-0 request.
interface filter_sequencer_if #(parameter int ADDR_W = 13);
   logic              ap_start;
   logic              ap_ready;
   logic              ap_done;
   logic              ap_idle;
   logic [7:0]        sfr;
   logic [ADDR_W-1:0] acc_addr0;
   logic              acc_ce0;
   logic              acc_we0;

   // Sequencer side
   modport master (
      output ap_start, sfr,
      input  ap_ready, ap_done, ap_idle, acc_addr0, acc_ce0, acc_we0
   );

   // Accelerator side
   modport slave (
      input  ap_start, sfr,
      output ap_ready, ap_done, ap_idle, acc_addr0, acc_ce0, acc_we0
   );
endinterface

// File: rtl/filter_port_mux.sv
// RAM port-0 owner select: accelerator request or a plain VGA read.
module filter_port_mux #(
   parameter int ADDR_W = 13
) (
   input  logic              i_acc_sel,
   input  logic [ADDR_W-1:0] i_acc_addr0,
   input  logic              i_acc_ce0,
   input  logic              i_acc_we0,
   input  logic [ADDR_W-1:0] i_vga_addr,
   output logic [ADDR_W-1:0] o_ram_addr0,
   output logic              o_ram_ce0,
   output logic              o_ram_we0
);

   // VGA always reads (ce=1, we=0); the accelerator's enables pass straight through
   always_comb begin
      if (i_acc_sel) begin
         o_ram_addr0 = i_acc_addr0;
         o_ram_ce0   = i_acc_ce0;
         o_ram_we0   = i_acc_we0;
      end else begin
         o_ram_addr0 = i_vga_addr;
         o_ram_ce0   = 1'b1;
         o_ram_we0   = 1'b0;
      end
   end

endmodule

// File: rtl/filter_sequencer.sv
// Sequencer and RAM port-0 arbiter for the filter accelerator. Arms on a
// fresh DMOD enable edge, waits for vertical blanking, runs the accelerator
// start/done handshake with the VGA reader held off, and pulses done.
module filter_sequencer
   import filter_pkg::*;
#(
   parameter int ADDR_W    = FILTER_ADDR_W,
   parameter int TIMEOUT_W = 20
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [7:0]           i_dmod,
   input  logic                 i_vblank,
   filter_sequencer_if.master   acc,
   input  logic [ADDR_W-1:0]    i_vga_addr,
   output logic [ADDR_W-1:0]    o_ram_addr0,
   output logic                 o_ram_ce0,
   output logic                 o_ram_we0,
   output logic                 o_vga_hold,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_timeout
);

   logic [2:0]           state_reg;
   logic [2:0]           state_next;
   logic                 armed_reg;
   logic [7:0]           sfr_reg;
   logic [TIMEOUT_W-1:0] wdog_reg;
   logic [TIMEOUT_W-1:0] wdog_next;
   logic                 enable;
   logic                 wdog_fire;

   // ap_idle carries no information the sequencer needs
   logic unused_ap_idle;
   assign unused_ap_idle = acc.ap_idle;

   assign enable    = i_dmod[DMOD_EN];
   assign wdog_next = wdog_reg + 1'b1;
   // RUN lasts 2^TIMEOUT_W - 1 cycles: the count would hit all-ones on the ERR edge
   assign wdog_fire = (wdog_next == {TIMEOUT_W{1'b1}});

   // Next-state decode
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (armed_reg && enable) state_next = ST_WAIT_BLANK;
         end
         ST_WAIT_BLANK: begin
            if (!enable)       state_next = ST_IDLE;
            else if (i_vblank) state_next = ST_START;
         end
         ST_START: begin
            if (acc.ap_ready) state_next = acc.ap_done ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (acc.ap_done)    state_next = ST_DONE;
            else if (wdog_fire) state_next = ST_ERR;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         ST_ERR: begin
            if (!enable) state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_reg <= ST_IDLE;
      else          state_reg <= state_next;
   end

   // Armed only after enable is seen low in IDLE, so each run needs a new 0->1
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         armed_reg <= 1'b0;
      end else if (state_reg == ST_IDLE) begin
         if (!enable)                     armed_reg <= 1'b1;
         else if (state_next != ST_IDLE)  armed_reg <= 1'b0;
      end else begin
         armed_reg <= 1'b0;
      end
   end

   // DMOD snapshot taken at arm; later DMOD writes do not disturb a run
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         sfr_reg <= 8'h00;
      else if (state_reg == ST_IDLE && state_next == ST_WAIT_BLANK)
         sfr_reg <= i_dmod;
   end

   // Run watchdog: counts RUN cycles from zero on every entry
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         wdog_reg <= '0;
      else if (state_reg == ST_RUN && state_next == ST_RUN)
         wdog_reg <= wdog_next;
      else
         wdog_reg <= '0;
   end

   assign acc.ap_start = (state_reg == ST_START);
   assign acc.sfr      = sfr_reg;
   assign o_done       = (state_reg == ST_DONE);
   assign o_timeout    = (state_reg == ST_ERR);
   assign o_busy       = (state_reg != ST_IDLE) && (state_reg != ST_ERR);
   assign o_vga_hold   = (state_reg == ST_START) || (state_reg == ST_RUN) ||
                         (state_reg == ST_DONE);

   filter_port_mux #(.ADDR_W(ADDR_W)) u_port_mux (
      .i_acc_sel   (acc_owns_port(state_reg)),
      .i_acc_addr0 (acc.acc_addr0),
      .i_acc_ce0   (acc.acc_ce0),
      .i_acc_we0   (acc.acc_we0),
      .i_vga_addr  (i_vga_addr),
      .o_ram_addr0 (o_ram_addr0),
      .o_ram_ce0   (o_ram_ce0),
      .o_ram_we0   (o_ram_we0)
   );

endmodule

// File: tb/tb_filter_sequencer.sv
// Directed bench for filter_sequencer: a per-cycle vector table for the
// basic run/retrigger flow, then hand-written multi-cycle sequences.
module tb_filter_sequencer;

   localparam int AW = 13;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    dmod = 8'h00;
   logic          vblank = 1'b0;
   logic          ap_ready = 1'b0;
   logic          ap_done = 1'b0;
   logic [AW-1:0] acc_addr = '0;
   logic          acc_ce = 1'b0;
   logic          acc_we = 1'b0;
   logic [AW-1:0] vga_addr = 13'h155;

   logic [AW-1:0] ram_addr, wd_ram_addr;
   logic          ram_ce, ram_we, vga_hold, busy, done_p, timeout;
   logic          wd_ram_ce, wd_ram_we, wd_vga_hold, wd_busy, wd_done, wd_timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   filter_sequencer_if #(.ADDR_W(AW)) acc_if ();
   filter_sequencer_if #(.ADDR_W(AW)) wd_if ();

   assign acc_if.ap_ready  = ap_ready;
   assign acc_if.ap_done   = ap_done;
   assign acc_if.ap_idle   = 1'b0;
   assign acc_if.acc_addr0 = acc_addr;
   assign acc_if.acc_ce0   = acc_ce;
   assign acc_if.acc_we0   = acc_we;
   assign wd_if.ap_ready   = ap_ready;
   assign wd_if.ap_done    = ap_done;
   assign wd_if.ap_idle    = 1'b0;
   assign wd_if.acc_addr0  = acc_addr;
   assign wd_if.acc_ce0    = acc_ce;
   assign wd_if.acc_we0    = acc_we;

   filter_sequencer #(.ADDR_W(AW), .TIMEOUT_W(20)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_dmod(dmod), .i_vblank(vblank),
      .acc(acc_if.master), .i_vga_addr(vga_addr),
      .o_ram_addr0(ram_addr), .o_ram_ce0(ram_ce), .o_ram_we0(ram_we),
      .o_vga_hold(vga_hold), .o_busy(busy), .o_done(done_p), .o_timeout(timeout)
   );

   filter_sequencer #(.ADDR_W(AW), .TIMEOUT_W(4)) dut_wd (
      .i_clk(clk), .i_rst_n(rst_n), .i_dmod(dmod), .i_vblank(vblank),
      .acc(wd_if.master), .i_vga_addr(vga_addr),
      .o_ram_addr0(wd_ram_addr), .o_ram_ce0(wd_ram_ce), .o_ram_we0(wd_ram_we),
      .o_vga_hold(wd_vga_hold), .o_busy(wd_busy), .o_done(wd_done), .o_timeout(wd_timeout)
   );

   typedef struct {
      logic [7:0]    dmod;
      logic          vb, rdy, dn, ce, we;
      logic [AW-1:0] aaddr;
      logic          e_start, e_done, e_busy, e_hold;
      logic [7:0]    e_sfr;
      logic [AW-1:0] e_addr;
      logic          e_ce, e_we;
   } vec_t;

   vec_t vecs [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int starts, dones, run_cyc, hold_bad, bad, wd_run;
      bit finished;

      // Vectors: inputs for a cycle, and the outputs expected during that cycle
      //            dmod   vb rdy dn ce we aaddr    st dn bz hd sfr    addr     ce we
      vecs[0]  = '{8'h00, 0, 0, 0, 1, 1, 13'h0AA,  0, 0, 0, 0, 8'h00, 13'h155, 1, 0};
      vecs[1]  = '{8'h2B, 0, 0, 0, 1, 1, 13'h0AA,  0, 0, 0, 0, 8'h00, 13'h155, 1, 0};
      vecs[2]  = '{8'h2B, 0, 0, 0, 1, 1, 13'h0AA,  0, 0, 1, 0, 8'h2B, 13'h155, 1, 0};
      vecs[3]  = '{8'h2B, 1, 0, 0, 1, 1, 13'h0AA,  0, 0, 1, 0, 8'h2B, 13'h155, 1, 0};
      vecs[4]  = '{8'h03, 1, 0, 0, 1, 0, 13'h0AA,  1, 0, 1, 1, 8'h2B, 13'h0AA, 1, 0};
      vecs[5]  = '{8'h03, 1, 0, 0, 0, 1, 13'h0B1,  1, 0, 1, 1, 8'h2B, 13'h0B1, 0, 1};
      vecs[6]  = '{8'h03, 1, 1, 0, 1, 1, 13'h0C2,  1, 0, 1, 1, 8'h2B, 13'h0C2, 1, 1};
      vecs[7]  = '{8'h03, 1, 0, 0, 1, 1, 13'h0D3,  0, 0, 1, 1, 8'h2B, 13'h0D3, 1, 1};
      vecs[8]  = '{8'h03, 1, 0, 1, 0, 0, 13'h0E4,  0, 0, 1, 1, 8'h2B, 13'h0E4, 0, 0};
      vecs[9]  = '{8'h03, 1, 0, 1, 1, 1, 13'h0F5,  0, 1, 1, 1, 8'h2B, 13'h155, 1, 0};
      vecs[10] = '{8'h03, 1, 0, 0, 1, 1, 13'h0AA,  0, 0, 0, 0, 8'h2B, 13'h155, 1, 0};
      vecs[11] = '{8'h03, 1, 0, 1, 1, 1, 13'h0AA,  0, 0, 0, 0, 8'h2B, 13'h155, 1, 0};
      vecs[12] = '{8'h00, 1, 0, 0, 1, 1, 13'h0AA,  0, 0, 0, 0, 8'h2B, 13'h155, 1, 0};
      vecs[13] = '{8'h05, 1, 0, 0, 1, 1, 13'h0AA,  0, 0, 0, 0, 8'h2B, 13'h155, 1, 0};
      vecs[14] = '{8'h05, 1, 0, 0, 1, 1, 13'h0AA,  0, 0, 1, 0, 8'h05, 13'h155, 1, 0};
      vecs[15] = '{8'h05, 1, 1, 1, 1, 1, 13'h0AA,  1, 0, 1, 1, 8'h05, 13'h0AA, 1, 1};
      vecs[16] = '{8'h05, 1, 0, 0, 1, 1, 13'h0AA,  0, 1, 1, 1, 8'h05, 13'h155, 1, 0};
      vecs[17] = '{8'h05, 1, 0, 0, 1, 1, 13'h0AA,  0, 0, 0, 0, 8'h05, 13'h155, 1, 0};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst busy", busy, 0);
      check("rst start", acc_if.ap_start, 0);
      check("rst sfr", acc_if.sfr, 8'h00);
      check("rst ram_addr", ram_addr, 13'h155);
      check("rst ram_ce_we", {ram_ce, ram_we}, 2'b10);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven run, retrigger block and re-arm
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         dmod = vecs[i].dmod; vblank = vecs[i].vb; ap_ready = vecs[i].rdy;
         ap_done = vecs[i].dn; acc_ce = vecs[i].ce; acc_we = vecs[i].we;
         acc_addr = vecs[i].aaddr;
         #1;
         $display("row %0d dmod=%h start=%b done=%b busy=%b hold=%b sfr=%h addr=%h ce=%b we=%b",
                  i, dmod, acc_if.ap_start, done_p, busy, vga_hold, acc_if.sfr, ram_addr, ram_ce, ram_we);
         check($sformatf("row%0d start", i), acc_if.ap_start, vecs[i].e_start);
         check($sformatf("row%0d done", i), done_p, vecs[i].e_done);
         check($sformatf("row%0d busy", i), busy, vecs[i].e_busy);
         check($sformatf("row%0d hold", i), vga_hold, vecs[i].e_hold);
         check($sformatf("row%0d sfr", i), acc_if.sfr, vecs[i].e_sfr);
         check($sformatf("row%0d addr", i), ram_addr, vecs[i].e_addr);
         check($sformatf("row%0d ce", i), ram_ce, vecs[i].e_ce);
         check($sformatf("row%0d we", i), ram_we, vecs[i].e_we);
         check($sformatf("row%0d timeout", i), timeout, 0);
      end

      // Normal run: ready on the 3rd start cycle, done in the 100th RUN cycle
      @(negedge clk);
      dmod = 8'h00; ap_ready = 0; ap_done = 0; vblank = 1; acc_ce = 1; acc_we = 1;
      @(negedge clk);
      dmod = 8'h09;
      starts = 0; dones = 0; run_cyc = 0; hold_bad = 0; finished = 0;
      for (int i = 0; i < 400 && !finished; i++) begin
         @(negedge clk);
         ap_ready = acc_if.ap_start && (starts == 2);
         ap_done  = busy && vga_hold && !acc_if.ap_start && !done_p && (run_cyc == 99);
         #1;
         if (acc_if.ap_start) starts++;
         if (busy && vga_hold && !acc_if.ap_start && !done_p) run_cyc++;
         if (done_p) begin
            dones++;
            if (!vga_hold) hold_bad++;
         end
         if (dones > 0 && !done_p) finished = 1;
      end
      $display("normal run: starts=%0d run_cycles=%0d done_pulses=%0d", starts, run_cyc, dones);
      check("normal start cycles", starts, 3);
      check("normal run cycles", run_cyc, 100);
      check("normal done pulses", dones, 1);
      check("normal hold in done", hold_bad, 0);
      check("normal busy after", busy, 0);
      check("normal hold after", vga_hold, 0);
      check("normal vga owns", ram_addr, vga_addr);
      check("normal sfr", acc_if.sfr, 8'h09);
      ap_ready = 0; ap_done = 0;

      // Enable still high: no retrigger
      starts = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (acc_if.ap_start || busy) starts++;
      end
      check("no retrigger", starts, 0);

      // Blank wait: 50 cycles without vblank keep the accelerator off the port
      @(negedge clk);
      dmod = 8'h00; vblank = 0; acc_addr = 13'h0777;
      @(negedge clk);
      dmod = 8'h01;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         if (acc_if.ap_start || ram_addr != vga_addr || !ram_ce || ram_we || !busy) bad++;
      end
      $display("blank wait: bad cycles=%0d", bad);
      check("blank wait hold-off", bad, 0);
      vblank = 1;
      @(negedge clk);
      #1;
      check("blank start", acc_if.ap_start, 1);
      check("blank acc owns", ram_addr, 13'h0777);
      ap_ready = 1; ap_done = 1;
      @(negedge clk);
      ap_ready = 0; ap_done = 0;
      #1;
      check("blank done", done_p, 1);

      // Abort from WAIT_BLANK
      @(negedge clk);
      dmod = 8'h00; vblank = 0;
      @(negedge clk);
      dmod = 8'h0D;
      @(negedge clk);
      #1;
      check("abort wait busy", busy, 1);
      dmod = 8'h00;
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         if (done_p || busy) dones++;
      end
      $display("abort: sfr=%h busy=%b", acc_if.sfr, busy);
      check("abort no done", dones, 0);
      check("abort sfr kept", acc_if.sfr, 8'h0D);

      // Watchdog on the TIMEOUT_W=4 instance
      @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      dmod = 8'h00;
      @(negedge clk);
      dmod = 8'h01; vblank = 1; ap_ready = 1; ap_done = 0;
      wd_run = 0; finished = 0;
      for (int i = 0; i < 100 && !finished; i++) begin
         @(negedge clk);
         #1;
         if (wd_timeout) finished = 1;
         else if (wd_busy && wd_vga_hold && !wd_if.ap_start && !wd_done) wd_run++;
      end
      $display("watchdog: run cycles=%0d timeout=%b", wd_run, wd_timeout);
      check("wd run cycles", wd_run, 15);
      check("wd timeout", wd_timeout, 1);
      check("wd busy", wd_busy, 0);
      check("wd hold", wd_vga_hold, 0);
      check("wd vga owns", {wd_ram_addr, wd_ram_ce, wd_ram_we}, {vga_addr, 2'b10});
      for (int i = 0; i < 3; i++) @(negedge clk);
      #1;
      check("wd sticky", wd_timeout, 1);
      dmod = 8'h00;
      @(negedge clk);
      #1;
      check("wd cleared", wd_timeout, 0);
      check("wd idle busy", wd_busy, 0);

      // Async reset with the default instance still in RUN
      ap_ready = 0;
      vga_addr = 13'h1ABC;
      acc_addr = 13'h0123;
      #1;
      check("pre-reset busy", busy, 1);
      check("pre-reset acc owns", ram_addr, 13'h0123);
      #2;
      rst_n = 0;
      #1;
      $display("async reset: addr=%h busy=%b hold=%b start=%b", ram_addr, busy, vga_hold, acc_if.ap_start);
      check("areset start", acc_if.ap_start, 0);
      check("areset busy", busy, 0);
      check("areset hold", vga_hold, 0);
      check("areset sfr", acc_if.sfr, 8'h00);
      check("areset addr", ram_addr, 13'h1ABC);
      check("areset ce_we", {ram_ce, ram_we}, 2'b10);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
